// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory boot loader: loader FSM
// state encoding, word/byte geometry and a small state-decode helper.
// Build option: IMEM_LOADER_CHECKSUM_EN adds the CSUM state (trailing
// XOR checksum word after the instruction payload).
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_LOAD  = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM  = 3'd3,
`endif
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    // Where the FSM goes once the instruction payload (possibly empty) is
    // complete: the checksum word still has to arrive when that is enabled.
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t ST_AFTER_PAYLOAD = ST_CSUM;
`else
    localparam state_t ST_AFTER_PAYLOAD = ST_DONE;
`endif

    // States in which a session is in progress and stream bytes are taken.
    function automatic logic is_busy(input state_t s);
        logic b;
        b = (s == ST_LEN) || (s == ST_LOAD);
`ifdef IMEM_LOADER_CHECKSUM_EN
        b = b || (s == ST_CSUM);
`endif
        return b;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer
// Collects stream bytes MSB-first into 32-bit words. A 2-bit counter tracks
// the byte position; the word is presented combinationally together with
// word_valid on the cycle its 4th byte is accepted.
// Ports:
//   clock, reset_n       : clock and asynchronous active-low reset
//   clear                : restart packing at byte 0 (session start)
//   byte_valid/byte_data : byte accepted this cycle
//   word_valid/word      : completed word (valid only when the 4th byte lands)
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [1:0]               cnt_q, cnt_d;
    logic [WORD_W-BYTE_W-1:0] shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_valid) begin
            // Counter wraps naturally from 3 back to 0 at the end of a word.
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[WORD_W-2*BYTE_W-1:0], byte_data};
        end
    end

    assign word_valid = byte_valid && !clear && (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word       = {shift_q, byte_data};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Boot-time program loader: receives a length word N followed by N big-endian
// instruction words over a valid/ready byte stream, writes them to consecutive
// instruction-memory word addresses from 0, then releases the core.
// Build option: IMEM_LOADER_CHECKSUM_EN appends a checksum word that must
// equal the XOR of all instruction words for the load to succeed.
// Ports:
//   clock, reset_n                  : clock, asynchronous active-low reset
//   start                           : begin a session (ignored while busy)
//   rx_data, rx_valid, rx_ready     : byte stream handshake
//   imem_we, imem_addr, imem_wdata  : registered instruction-memory write port
//   core_run                        : core released (only after a good load)
//   busy, done, error               : session status (done/error sticky)
//   words_loaded                    : instruction words written this session
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_run,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     words_loaded_q, words_loaded_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [WORD_W-1:0]   imem_wdata_q, imem_wdata_d;
    logic                imem_we_q, imem_we_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0]   csum_q, csum_d;
`endif

    logic                busy_c;
    logic                accept;
    logic                session_start;
    logic                word_valid;
    logic [WORD_W-1:0]   word;
    logic [WORD_W-1:0]   len_upper;

    assign busy_c        = is_busy(state_q);
    assign accept        = rx_valid && busy_c;
    assign session_start = start && !busy_c;
    // Any bit of N above the ADDR_W+1 compared bits makes the length invalid.
    assign len_upper     = word >> (ADDR_W + 1);

    byte_packer u_packer (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (session_start),
        .byte_valid (accept),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        words_loaded_d = words_loaded_q;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        imem_we_d      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d         = csum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (session_start) begin
                    state_d        = ST_LEN;
                    len_d          = '0;
                    words_loaded_d = '0;
                    imem_addr_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d         = '0;
`endif
                end
            end
            ST_LEN: begin
                if (word_valid) begin
                    if ((|len_upper) || (word[ADDR_W:0] > CAPACITY)) begin
                        state_d = ST_ERROR;
                    end else if (word[ADDR_W:0] == '0) begin
                        state_d = ST_AFTER_PAYLOAD;
                    end else begin
                        state_d = ST_LOAD;
                        len_d   = word[ADDR_W:0];
                    end
                end
            end
            ST_LOAD: begin
                // The write address is the number of words already written,
                // so words_loaded doubles as the address counter.
                if (word_valid) begin
                    imem_we_d      = 1'b1;
                    imem_addr_d    = words_loaded_q[ADDR_W-1:0];
                    imem_wdata_d   = word;
                    words_loaded_d = words_loaded_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d         = csum_q ^ word;
`endif
                    if (words_loaded_d == len_q) begin
                        state_d = ST_AFTER_PAYLOAD;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (word_valid) begin
                    state_d = (word == csum_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            len_q          <= '0;
            words_loaded_q <= '0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            imem_we_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            words_loaded_q <= words_loaded_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            imem_we_q      <= imem_we_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign rx_ready     = busy_c;
    assign busy         = busy_c;
    assign core_run     = (state_q == ST_DONE);
    assign done         = (state_q == ST_DONE);
    assign error        = (state_q == ST_ERROR);
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Drives imem_loader with directed and randomized byte streams and checks the
// captured instruction-memory writes and final status against a reference
// model that works on whole stream words.
// Build option: IMEM_LOADER_CHECKSUM_EN (must match the RTL build).
module tb_imem_loader;

   localparam int ADDR_W = 8;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_run;
   logic              busy;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   int testCount = 0;
   int failCount = 0;

   logic [31:0]       stim[$];
   logic [ADDR_W-1:0] capAddr[$];
   logic [31:0]       capData[$];

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .start        (start),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_run     (core_run),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   // Record every write the loader performs, sampled mid-cycle.
   always @(negedge clock) begin
      if (imem_we === 1'b1) begin
         capAddr.push_back(imem_addr);
         capData.push_back(imem_wdata);
      end
   end

   // Hard stop in case something stalls forever.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed no completion, expected finish before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it, and on mismatch counts and reports the failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Offers one byte, optionally after a random idle gap, and waits for it to be taken.
   task automatic sendByte(input logic [7:0] b, input bit gaps);
      int waitCycles;
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            rx_data = 8'($urandom);
            @(negedge clock);
         end
      end
      waitCycles = 0;
      while (rx_ready !== 1'b1 && waitCycles < 20) begin
         @(negedge clock);
         waitCycles++;
      end
      checkOutput("rx_ready_before_byte", {31'b0, rx_ready}, 32'd1);
      if (rx_ready === 1'b1) begin
         rx_data  = b;
         rx_valid = 1'b1;
         @(posedge clock);
         @(negedge clock);
         rx_valid = 1'b0;
      end
   endtask

   function automatic logic [31:0] xorPayload(input int n);
      logic [31:0] x;
      x = '0;
      for (int i = 1; i <= n; i++) x ^= stim[i];
      return x;
   endfunction

   function automatic bit lengthOk(input logic [31:0] n);
      return n <= (32'd1 << ADDR_W);
   endfunction

   // Starts a session and streams every word of stim; each instruction word
   // must produce a write in the cycle right after its last byte.
   task automatic applyStimulus(input bit gaps, input bit pokeStart);
      logic [31:0] n;
      bit          lenOk;
      n     = stim[0];
      lenOk = lengthOk(n);
      capAddr.delete();
      capData.delete();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < stim.size(); i++) begin
         for (int b = 3; b >= 0; b--) sendByte(stim[i][8*b +: 8], gaps);
         if (lenOk && i >= 1 && i <= int'(n)) begin
            checkOutput("we_after_word", {31'b0, imem_we}, 32'd1);
            checkOutput("addr_after_word", {24'b0, imem_addr}, 32'(i - 1));
         end
         if (pokeStart && i == 1 && i < stim.size() - 1) begin
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
         end
      end
      rx_valid = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   // Reference model: a valid length writes words 1..N at addresses 0..N-1;
   // the load succeeds if the length is valid (and the checksum matches).
   task automatic checkSession();
      logic [31:0] n;
      bit          lenOk;
      bit          expDone;
      int          expWords;
      n        = stim[0];
      lenOk    = lengthOk(n);
      expWords = lenOk ? int'(n) : 0;
      expDone  = lenOk;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (lenOk) expDone = (stim.size() > expWords + 1) && (stim[expWords + 1] == xorPayload(expWords));
`endif
      checkOutput("num_writes", 32'(capAddr.size()), 32'(expWords));
      for (int i = 0; i < capAddr.size() && i < expWords; i++) begin
         checkOutput("write_addr", {24'b0, capAddr[i]}, 32'(i));
         checkOutput("write_data", capData[i], stim[i + 1]);
      end
      checkOutput("done", {31'b0, done}, {31'b0, expDone});
      checkOutput("core_run", {31'b0, core_run}, {31'b0, expDone});
      checkOutput("error", {31'b0, error}, {31'b0, !expDone});
      checkOutput("busy_end", {31'b0, busy}, 32'd0);
      checkOutput("rx_ready_end", {31'b0, rx_ready}, 32'd0);
      checkOutput("words_loaded", {23'b0, words_loaded}, 32'(expWords));
   endtask

   // Fills stim with a length, n random words and (when enabled) a checksum.
   task automatic buildRandom(input int n, input bit goodCsum);
      stim.delete();
      stim.push_back(32'(n));
      for (int i = 0; i < n; i++) stim.push_back($urandom);
`ifdef IMEM_LOADER_CHECKSUM_EN
      stim.push_back(goodCsum ? xorPayload(n) : (xorPayload(n) ^ 32'h0000_0100));
`else
      if (!goodCsum) stim.push_back($urandom);
`endif
   endtask

   task automatic appendChecksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
      stim.push_back(xorPayload(int'(stim[0])));
`endif
   endtask

   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      repeat (3) @(negedge clock);

      // Reset state.
      checkOutput("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
      checkOutput("rst_imem_we", {31'b0, imem_we}, 32'd0);
      checkOutput("rst_core_run", {31'b0, core_run}, 32'd0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_done", {31'b0, done}, 32'd0);
      checkOutput("rst_error", {31'b0, error}, 32'd0);
      checkOutput("rst_imem_addr", {24'b0, imem_addr}, 32'd0);
      checkOutput("rst_imem_wdata", imem_wdata, 32'd0);
      checkOutput("rst_words_loaded", {23'b0, words_loaded}, 32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      // Idle loader ignores stream bytes.
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      repeat (2) @(negedge clock);
      rx_valid = 1'b0;
      checkOutput("idle_ignores_rx", {31'b0, busy}, 32'd0);

      // Three-instruction program, back-to-back bytes.
      stim = '{32'd3, 32'h2008_0005, 32'h2009_0005, 32'h1109_0001};
      appendChecksum();
      applyStimulus(1'b0, 1'b0);
      checkSession();

      // Same program with random valid gaps and a start pulse while busy.
      applyStimulus(1'b1, 1'b1);
      checkSession();

      // Empty program.
      stim = '{32'd0};
      appendChecksum();
      applyStimulus(1'b0, 1'b0);
      checkSession();

      // Length one beyond capacity, and a length with a high bit set.
      stim = '{32'h0000_0101};
      applyStimulus(1'b0, 1'b0);
      checkSession();
      stim = '{32'h0001_0003};
      applyStimulus(1'b1, 1'b0);
      checkSession();

      // Full-capacity program.
      buildRandom(1 << ADDR_W, 1'b1);
      applyStimulus(1'b0, 1'b0);
      checkSession();

      // Randomized programs with random gaps.
      for (int s = 0; s < 6; s++) begin
         buildRandom($urandom_range(1, 8), 1'b1);
         applyStimulus(1'($urandom_range(0, 1)), 1'b1);
         checkSession();
      end

      // Reset in the middle of a four-word load, then a fresh one-word load.
      stim = '{32'd4, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         for (int b = 3; b >= 0; b--) sendByte(stim[i][8*b +: 8], 1'b0);
      end
      repeat (2) @(negedge clock);
      checkOutput("mid_words_loaded", {23'b0, words_loaded}, 32'd2);
      reset_n = 1'b0;
      @(negedge clock);
      checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
      checkOutput("midrst_done", {31'b0, done}, 32'd0);
      checkOutput("midrst_words_loaded", {23'b0, words_loaded}, 32'd0);
      checkOutput("midrst_imem_addr", {24'b0, imem_addr}, 32'd0);
      reset_n = 1'b1;
      @(negedge clock);
      stim = '{32'd1, 32'hDEAD_BEEF};
      appendChecksum();
      applyStimulus(1'b0, 1'b0);
      checkSession();

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum match and mismatch.
      stim = '{32'd2, 32'hAAAA_0000, 32'h0000_AAAA, 32'hAAAA_AAAA};
      applyStimulus(1'b0, 1'b0);
      checkSession();
      checkOutput("csum_good_done", {31'b0, done}, 32'd1);
      stim = '{32'd2, 32'hAAAA_0000, 32'h0000_AAAA, 32'hAAAA_AAAB};
      applyStimulus(1'b1, 1'b0);
      checkSession();
      checkOutput("csum_bad_core_run", {31'b0, core_run}, 32'd0);
      buildRandom($urandom_range(1, 5), 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkSession();
`endif

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
